// File: rtl/alu_uart_interface_if.sv
// Byte-link / ALU bundle for alu_uart_interface.
// slave: the sequencer side; master: the UART/ALU environment side.
interface alu_uart_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_data_a;
    logic [NB_DATA-1:0] o_alu_data_b;
    logic [NB_OP-1:0]   o_alu_operation;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_drop;
    logic               o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_data_a, o_alu_data_b, o_alu_operation, o_tx_data,
        output o_tx_start, o_busy, o_drop, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_data_a, o_alu_data_b, o_alu_operation, o_tx_data,
        input  o_tx_start, o_busy, o_drop, o_timeout
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Sequencer between the UART byte link and the combinational ALU (A, B, opcode in; result byte out).
// Optional inter-byte timeout enabled by defining ALU_IF_TIMEOUT_EN.
//
// state   | meaning
// WAIT_A  | idle, next byte is operand A
// WAIT_B  | next byte is operand B
// WAIT_OP | next byte is the opcode
// EXEC    | ALU settling, result captured at end of cycle
// START   | request transmit (o_tx_start appears next cycle)
// WAIT_TX | waiting for transmitter to finish
module alu_uart_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    alu_uart_interface_if.slave  bus
);
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        START   = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               drop_q, drop_d;

`ifdef ALU_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        drop_d     = 1'b0;
        case (state_q)
            WAIT_A: if (bus.i_rx_done) begin
                alu_a_d = bus.i_rx_data;
                state_d = WAIT_B;
            end
            WAIT_B: if (bus.i_rx_done) begin
                alu_b_d = bus.i_rx_data;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (bus.i_rx_done) begin
                alu_op_d = bus.i_rx_data[NB_OP-1:0];
                state_d  = EXEC;
            end
            EXEC: begin
                tx_data_d = bus.i_alu_result;
                drop_d    = bus.i_rx_done;
                state_d   = START;
            end
            START: begin
                tx_start_d = 1'b1;
                drop_d     = bus.i_rx_done;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                // a byte landing with tx_done is still dropped; we are not yet back in WAIT_A
                drop_d = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase

`ifdef ALU_IF_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (bus.i_rx_done && (state_q == WAIT_A || state_q == WAIT_B || state_q == WAIT_OP)) begin
            cnt_d = CNT_LOAD;
        end else if (state_q == WAIT_B || state_q == WAIT_OP) begin
            if (cnt_q == '0) begin
                state_d   = WAIT_A;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            drop_q     <= drop_d;
        end
    end

`ifdef ALU_IF_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.o_timeout = timeout_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_alu_data_a    = alu_a_q;
    assign bus.o_alu_data_b    = alu_b_q;
    assign bus.o_alu_operation = alu_op_q;
    assign bus.o_tx_data       = tx_data_q;
    assign bus.o_tx_start      = tx_start_q;
    assign bus.o_drop          = drop_q;
    assign bus.o_busy          = (state_q != WAIT_A);
endmodule
